// File: rtl/vid_pkg.sv
// Shared types and default geometry for the video line-fetch controller.
// Frame geometry assumes 1024 px x 16 b lines packed into 128 b words.
package vid_pkg;

    localparam int VID_LINE_WORDS  = 128;
    localparam int VID_BURST_WORDS = 64;
    localparam int VID_V_LINES     = 500;
    localparam int VID_PREFETCH    = 2;
    localparam int VID_ADDR_W      = 28;
    localparam int VID_FB_BASE     = 0;
    localparam int VID_FRAME_WORDS = 64000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } vlf_state_e;

endpackage

// File: rtl/vid_line_fetch_ctrl_if.sv
// Read-command bus between the line-fetch controller and the DDR3 read port.
// Master drives the command, slave answers with ready.
interface vid_line_fetch_ctrl_if
    import vid_pkg::*;
#(
    parameter int ADDR_W = VID_ADDR_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [7:0]        cmd_len;

    modport master (
        output cmd_valid,
        output cmd_addr,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_addr,
        input  cmd_len,
        output cmd_ready
    );

endinterface

// File: rtl/vlf_edge_det.sv
// Registered rise/fall detector; edges appear one cycle after the input moves.
// Two flops also resynchronise the timing-generator level.
module vlf_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = sig_i;
        s2_d = s1_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign rise_o = s1_q & ~s2_q;
    assign fall_o = ~s1_q & s2_q;

endmodule

// File: rtl/vid_line_fetch_ctrl.sv
// Schedules frame-buffer burst reads so displayed lines are prefetched ahead.
// VLF_PINGPONG_EN: adds wr_bank and reads from the bank opposite the camera.
module vid_line_fetch_ctrl
    import vid_pkg::*;
#(
    parameter int LINE_WORDS  = VID_LINE_WORDS,
    parameter int BURST_WORDS = VID_BURST_WORDS,
    parameter int V_LINES     = VID_V_LINES,
    parameter int PREFETCH    = VID_PREFETCH,
    parameter int ADDR_W      = VID_ADDR_W,
    parameter int FB_BASE     = VID_FB_BASE,
    parameter int FRAME_WORDS = VID_FRAME_WORDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vs_i,
    input  logic       rd_i,
    input  logic [9:0] buf_free,
`ifdef VLF_PINGPONG_EN
    input  logic       wr_bank,
`endif
    vid_line_fetch_ctrl_if.master cmd,
    output logic       frame_start,
    output logic [9:0] line_cnt,
    output logic       underrun
);

    localparam int BPL = LINE_WORDS / BURST_WORDS;
    localparam int BW  = (BPL > 1) ? $clog2(BPL) : 1;
    localparam logic [9:0]        LINES_MAX  = 10'(V_LINES);
    localparam logic [9:0]        BURST_FREE = 10'(BURST_WORDS);
    localparam logic [10:0]       AHEAD_MAX  = 11'(PREFETCH);
    localparam logic [ADDR_W-1:0] BURST_INC  = ADDR_W'(BURST_WORDS);
    localparam logic [BW-1:0]     LAST_BURST = BW'(BPL - 1);

    if (LINE_WORDS % BURST_WORDS != 0) begin : g_chk_line
        $error("LINE_WORDS must be a multiple of BURST_WORDS");
    end
    if (FRAME_WORDS < LINE_WORDS * V_LINES) begin : g_chk_frame
        $error("FRAME_WORDS too small for one frame");
    end

    vlf_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BW-1:0]     bidx_q, bidx_d;
    logic [9:0]        line_q, line_d;
    logic [9:0]        cons_q, cons_d;
    logic              under_q, under_d;
    logic              pend_q, pend_d;

    logic vs_rise, vs_fall_unused;
    logic rd_rise, rd_fall;
    logic issue, accept, frame_evt, can_issue;
    logic [ADDR_W-1:0] base_addr;

    vlf_edge_det u_vs_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (vs_i),
        .rise_o (vs_rise),
        .fall_o (vs_fall_unused)
    );

    vlf_edge_det u_rd_edge (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (rd_i),
        .rise_o (rd_rise),
        .fall_o (rd_fall)
    );

`ifdef VLF_PINGPONG_EN
    logic rd_bank;
    assign rd_bank   = ~wr_bank;
    assign base_addr = ADDR_W'(FB_BASE)
                     + (rd_bank ? ADDR_W'(FRAME_WORDS) : '0);
`else
    assign base_addr = ADDR_W'(FB_BASE);
`endif

    assign issue     = (state_q == ST_ISSUE);
    assign accept    = issue & cmd.cmd_ready;
    // A frame event seen mid-handshake is held until the command is taken.
    assign frame_evt = vs_rise | pend_q;
    assign can_issue = (buf_free >= BURST_FREE)
                    && ({1'b0, line_q} < {1'b0, cons_q} + AHEAD_MAX)
                    && (line_q < LINES_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_W'(FB_BASE);
            bidx_q  <= '0;
            line_q  <= '0;
            cons_q  <= '0;
            under_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bidx_q  <= bidx_d;
            line_q  <= line_d;
            cons_q  <= cons_d;
            under_q <= under_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (vs_rise) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_WAIT;
            ST_ISSUE: if (accept) state_d = frame_evt ? ST_FLUSH : ST_WAIT;
            ST_WAIT: begin
                if (vs_rise)                 state_d = ST_FLUSH;
                else if (line_q == LINES_MAX) state_d = ST_DONE;
                else if (can_issue)          state_d = ST_ISSUE;
            end
            ST_DONE:  if (vs_rise) state_d = ST_FLUSH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        bidx_d  = bidx_q;
        line_d  = line_q;
        cons_d  = cons_q;
        under_d = under_q;
        pend_d  = issue & frame_evt & ~accept;
        if (state_q == ST_FLUSH) begin
            addr_d  = base_addr;
            bidx_d  = '0;
            line_d  = '0;
            cons_d  = '0;
            under_d = 1'b0;
        end else begin
            if (accept) begin
                addr_d = addr_q + BURST_INC;
                if (bidx_q == LAST_BURST) begin
                    bidx_d = '0;
                    line_d = line_q + 10'd1;
                end else begin
                    bidx_d = bidx_q + BW'(1);
                end
            end
            if (rd_fall && (cons_q < LINES_MAX)) cons_d = cons_q + 10'd1;
            if (rd_rise && (line_q == cons_q))   under_d = 1'b1;
        end
    end

    always_comb begin
        cmd.cmd_valid = issue;
        cmd.cmd_addr  = addr_q;
        cmd.cmd_len   = issue ? 8'(BURST_WORDS) : 8'd0;
        frame_start   = (state_q == ST_FLUSH);
        line_cnt      = line_q;
        underrun      = under_q;
    end

endmodule

// File: tb/tb_vid_line_fetch_ctrl.sv
// Self-checking bench for vid_line_fetch_ctrl with randomized frame traffic.
// Build with VLF_PINGPONG_EN to also exercise bank selection.
module tb_vid_line_fetch_ctrl;

    localparam int AW = 28;

    logic       clk = 1'b0;
    logic       rst;
    logic       vs_i;
    logic       rd_i;
    logic [9:0] buf_free;
    logic       frame_start;
    logic [9:0] line_cnt;
    logic       underrun;
`ifdef VLF_PINGPONG_EN
    logic       wr_bank;
`endif

    vid_line_fetch_ctrl_if #(.ADDR_W(AW)) cmd_if ();

    vid_line_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .vs_i        (vs_i),
        .rd_i        (rd_i),
        .buf_free    (buf_free),
`ifdef VLF_PINGPONG_EN
        .wr_bank     (wr_bank),
`endif
        .cmd         (cmd_if),
        .frame_start (frame_start),
        .line_cnt    (line_cnt),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] acc_addr[$];
    logic [7:0]    acc_len[$];
    int            acc_cons[$];
    int            m_cons = 0;
    int            fs_cnt = 0;
    int            vld_cnt = 0;
    bit            ff_done = 0;

    // Log of accepted commands with the consumed-line count at that moment
    always @(negedge clk) begin
        if (frame_start) fs_cnt++;
        if (cmd_if.cmd_valid) vld_cnt++;
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
            acc_addr.push_back(cmd_if.cmd_addr);
            acc_len.push_back(cmd_if.cmd_len);
            acc_cons.push_back(m_cons);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        acc_addr.delete();
        acc_len.delete();
        acc_cons.delete();
    endtask

    task automatic frame_pulse();
        m_cons = 0;
        vs_i = 1'b1;
        tick(3);
        vs_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        sample();
        checks++;
        if (cmd_if.cmd_valid !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got valid=%b fs=%b want 0 0",
                     cmd_if.cmd_valid, frame_start);
        end
        checks++;
        if (cmd_if.cmd_addr !== '0 || cmd_if.cmd_len !== 8'd0) begin
            errors++;
            $display("FAIL reset_cmd got addr=%0d len=%0d want 0 0",
                     cmd_if.cmd_addr, cmd_if.cmd_len);
        end
        checks++;
        if (line_cnt !== 10'd0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_cnt got line=%0d und=%b want 0 0",
                     line_cnt, underrun);
        end
        tick(1);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_frame_start();
        int fs0;
        buf_free = 10'd512;
        cmd_if.cmd_ready = 1'b1;
        clear_log();
        fs0 = fs_cnt;
        frame_pulse();
        tick(40);
        checks++;
        if (fs_cnt - fs0 !== 1) begin
            errors++;
            $display("FAIL fs_pulse got %0d cycles want 1", fs_cnt - fs0);
        end
        checks++;
        if (acc_addr.size() !== 4) begin
            errors++;
            $display("FAIL prefetch_cmds got %0d want 4", acc_addr.size());
        end
        for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
            checks++;
            if (acc_addr[i] !== AW'(i * 64)) begin
                errors++;
                $display("FAIL first_addr[%0d] got %0d want %0d",
                         i, acc_addr[i], i * 64);
            end
        end
        if (acc_len.size() > 0) begin
            checks++;
            if (acc_len[0] !== 8'd64) begin
                errors++;
                $display("FAIL cmd_len got %0d want 64", acc_len[0]);
            end
        end
        checks++;
        if (line_cnt !== 10'd2 || cmd_if.cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL prefetch_stop got line=%0d valid=%b want 2 0",
                     line_cnt, cmd_if.cmd_valid);
        end
    endtask

    task automatic test_consume();
        rd_i = 1'b1;
        tick(4);
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL consume_no_und got %b want 0", underrun);
        end
        rd_i = 1'b0;
        m_cons++;
        tick(20);
        checks++;
        if (acc_addr.size() !== 6) begin
            errors++;
            $display("FAIL consume_cmds got %0d want 6", acc_addr.size());
        end else begin
            checks++;
            if (acc_addr[4] !== AW'(256) || acc_addr[5] !== AW'(320)) begin
                errors++;
                $display("FAIL consume_addr got %0d %0d want 256 320",
                         acc_addr[4], acc_addr[5]);
            end
        end
        checks++;
        if (line_cnt !== 10'd3) begin
            errors++;
            $display("FAIL consume_line got %0d want 3", line_cnt);
        end
    endtask

    task automatic test_stall();
        bit seen;
        int bad;
        cmd_if.cmd_ready = 1'b0;
        buf_free = 10'd512;
        clear_log();
        frame_pulse();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (cmd_if.cmd_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL stall_valid got timeout want valid");
        end
        checks++;
        if (cmd_if.cmd_addr !== '0) begin
            errors++;
            $display("FAIL stall_addr got %0d want 0", cmd_if.cmd_addr);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            sample();
            if (cmd_if.cmd_valid !== 1'b1 || cmd_if.cmd_addr !== '0 ||
                cmd_if.cmd_len !== 8'd64 || acc_addr.size() != 0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL stall_hold got %0d bad cycles want 0", bad);
        end
        @(posedge clk);
        #1;
        cmd_if.cmd_ready = 1'b1;
        sample();
        checks++;
        if (acc_addr.size() !== 1) begin
            errors++;
            $display("FAIL stall_accept got %0d cmds want 1", acc_addr.size());
        end
        tick(30);
        checks++;
        if (line_cnt !== 10'd2) begin
            errors++;
            $display("FAIL stall_line got %0d want 2", line_cnt);
        end
    endtask

    task automatic test_buf_free();
        int fs0;
        int v0;
        bit seen;
        cmd_if.cmd_ready = 1'b1;
        buf_free = 10'd32;
        clear_log();
        fs0 = fs_cnt;
        v0 = vld_cnt;
        frame_pulse();
        tick(20);
        checks++;
        if (fs_cnt - fs0 !== 1 || vld_cnt - v0 !== 0) begin
            errors++;
            $display("FAIL low_free got fs=%0d valid=%0d want 1 0",
                     fs_cnt - fs0, vld_cnt - v0);
        end
        buf_free = 10'd64;
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            sample();
            if (cmd_if.cmd_valid) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL free_64 got no valid want valid in 2 cycles");
        end
        buf_free = 10'd512;
        tick(30);
    endtask

    task automatic test_underrun();
        int fs0;
        bit seen;
        cmd_if.cmd_ready = 1'b0;
        buf_free = 10'd512;
        clear_log();
        frame_pulse();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            sample();
            if (cmd_if.cmd_valid) seen = 1;
        end
        checks++;
        if (!seen || underrun !== 1'b0) begin
            errors++;
            $display("FAIL und_pre got seen=%b und=%b want 1 0",
                     seen, underrun);
        end
        tick(1);
        rd_i = 1'b1;
        tick(4);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL und_set got %b want 1", underrun);
        end
        rd_i = 1'b0;
        tick(6);
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL und_sticky got %b want 1", underrun);
        end
        fs0 = fs_cnt;
        vs_i = 1'b1;
        tick(3);
        vs_i = 1'b0;
        tick(5);
        checks++;
        if (cmd_if.cmd_valid !== 1'b1 || fs_cnt - fs0 !== 0) begin
            errors++;
            $display("FAIL pend_hold got valid=%b fs=%0d want 1 0",
                     cmd_if.cmd_valid, fs_cnt - fs0);
        end
        cmd_if.cmd_ready = 1'b1;
        tick(6);
        checks++;
        if (fs_cnt - fs0 !== 1 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL und_clear got fs=%0d und=%b want 1 0",
                     fs_cnt - fs0, underrun);
        end
        tick(30);
        checks++;
        if (acc_addr.size() < 2) begin
            errors++;
            $display("FAIL pend_cmds got %0d want >=2", acc_addr.size());
        end else if (acc_addr[0] !== '0 || acc_addr[1] !== '0) begin
            errors++;
            $display("FAIL pend_addr got %0d %0d want 0 0",
                     acc_addr[0], acc_addr[1]);
        end
    endtask

    task automatic test_async_reset();
        bit seen;
        cmd_if.cmd_ready = 1'b1;
        buf_free = 10'd512;
        clear_log();
        frame_pulse();
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            sample();
            if (acc_addr.size() >= 2) seen = 1;
        end
        @(posedge clk);
        #1;
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 10 && seen && !cmd_if.cmd_valid; i++) sample();
        checks++;
        if (!seen || cmd_if.cmd_valid !== 1'b1 ||
            cmd_if.cmd_addr !== AW'(128) || line_cnt !== 10'd1) begin
            errors++;
            $display("FAIL mid_issue got valid=%b addr=%0d line=%0d want 1 128 1",
                     cmd_if.cmd_valid, cmd_if.cmd_addr, line_cnt);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (cmd_if.cmd_valid !== 1'b0 || cmd_if.cmd_addr !== '0 ||
            cmd_if.cmd_len !== 8'd0 || line_cnt !== 10'd0 ||
            frame_start !== 1'b0 || underrun !== 1'b0) begin
            errors++;
            $display("FAIL async_rst got valid=%b addr=%0d len=%0d line=%0d want 0 0 0 0",
                     cmd_if.cmd_valid, cmd_if.cmd_addr, cmd_if.cmd_len, line_cnt);
        end
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

`ifdef VLF_PINGPONG_EN
    task automatic test_pingpong();
        wr_bank = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        buf_free = 10'd512;
        clear_log();
        frame_pulse();
        tick(30);
        checks++;
        if (acc_addr.size() == 0 || acc_addr[0] !== AW'(64000)) begin
            errors++;
            $display("FAIL bank1_addr got %0d want 64000",
                     acc_addr.size() ? acc_addr[0] : '1);
        end
        wr_bank = 1'b1;
        clear_log();
        frame_pulse();
        tick(30);
        checks++;
        if (acc_addr.size() == 0 || acc_addr[0] !== '0) begin
            errors++;
            $display("FAIL bank0_addr got %0d want 0",
                     acc_addr.size() ? acc_addr[0] : '1);
        end
    endtask
`endif

    task automatic test_full_frame();
        int fs0;
        int v0;
        int bad_addr;
        int bad_len;
        int bad_flow;
        bit seen;
        cmd_if.cmd_ready = 1'b1;
        buf_free = 10'd512;
        clear_log();
        fs0 = fs_cnt;
        frame_pulse();
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            sample();
            if (line_cnt == 10'd2) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL ff_prefetch got line=%0d want 2", line_cnt);
        end
        tick(1);
        ff_done = 0;
        fork
            begin
                while (!ff_done) begin
                    cmd_if.cmd_ready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 7) == 0)
                        buf_free = 10'($urandom_range(0, 63));
                    else
                        buf_free = 10'($urandom_range(64, 1023));
                    tick(1);
                end
            end
            begin
                for (int w = 0; w < 500; w++) begin
                    rd_i = 1'b1;
                    tick($urandom_range(10, 20));
                    rd_i = 1'b0;
                    if (m_cons < 500) m_cons++;
                    tick($urandom_range(10, 20));
                end
                ff_done = 1;
            end
        join
        cmd_if.cmd_ready = 1'b1;
        buf_free = 10'd512;
        tick(60);
        checks++;
        if (acc_addr.size() !== 1000) begin
            errors++;
            $display("FAIL ff_count got %0d want 1000", acc_addr.size());
        end
        bad_addr = 0;
        bad_len = 0;
        bad_flow = 0;
        foreach (acc_addr[k]) begin
            if (acc_addr[k] !== AW'(k * 64)) bad_addr++;
            if (acc_len[k] !== 8'd64) bad_len++;
            if (k % 2 == 0 && !((k / 2) < acc_cons[k] + 2)) bad_flow++;
        end
        checks++;
        if (bad_addr !== 0 || bad_len !== 0) begin
            errors++;
            $display("FAIL ff_seq got bad_addr=%0d bad_len=%0d want 0 0",
                     bad_addr, bad_len);
        end
        checks++;
        if (bad_flow !== 0) begin
            errors++;
            $display("FAIL ff_prefetch_limit got %0d early lines want 0",
                     bad_flow);
        end
        if (acc_addr.size() > 0) begin
            checks++;
            if (acc_addr[acc_addr.size() - 1] !== AW'(63936)) begin
                errors++;
                $display("FAIL ff_last got %0d want 63936",
                         acc_addr[acc_addr.size() - 1]);
            end
        end
        checks++;
        if (line_cnt !== 10'd500 || underrun !== 1'b0 || fs_cnt - fs0 !== 1) begin
            errors++;
            $display("FAIL ff_end got line=%0d und=%b fs=%0d want 500 0 1",
                     line_cnt, underrun, fs_cnt - fs0);
        end
        v0 = vld_cnt;
        for (int w = 0; w < 3; w++) begin
            rd_i = 1'b1;
            tick(10);
            rd_i = 1'b0;
            tick(10);
        end
        tick(20);
        checks++;
        if (vld_cnt - v0 !== 0 || acc_addr.size() > 1000) begin
            errors++;
            $display("FAIL done_quiet got %0d valid cycles want 0",
                     vld_cnt - v0);
        end
    endtask

    initial begin
        rst = 1'b1;
        vs_i = 1'b0;
        rd_i = 1'b0;
        buf_free = 10'd0;
        cmd_if.cmd_ready = 1'b0;
`ifdef VLF_PINGPONG_EN
        wr_bank = 1'b1;
`endif
        test_reset();
        test_frame_start();
        test_consume();
        test_stall();
        test_buf_free();
        test_underrun();
        test_async_reset();
`ifdef VLF_PINGPONG_EN
        test_pingpong();
`endif
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
